// File: rtl/alu_inst_encoder.sv
// alu_inst_encoder: ALU op -> RV32I OP/OP-IMM encoder with output FIFO; in(valid/ready,alu_op,itype,rd,rs1,rs2,imm) out(valid/ready,inst) level err_pulse err_count
module alu_inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_alu_op,
  input  logic                       in_itype,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [11:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err_pulse,
  output logic [7:0]                 err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, LT = 4'd3, LTU = 4'd4, XOR = 4'd5,
                         SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9, NOP = 4'd10;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    f3;
  logic          legal, alt, shift, push, pop, bad;
  logic [11:0]   imm;
  logic [6:0]    f7;
  logic [31:0]   inst;
  always_comb begin
    f3    = 3'b000;
    legal = 1'b1;
    alt   = 1'b0;
    shift = 1'b0;
    case (in_alu_op)
      ADD: f3 = 3'b000;
      SUB: begin
        alt   = 1'b1;
        legal = !in_itype;
      end
      SLL: begin
        f3    = 3'b001;
        shift = 1'b1;
      end
      LT:  f3 = 3'b010;
      LTU: f3 = 3'b011;
      XOR: f3 = 3'b100;
      SRL: begin
        f3    = 3'b101;
        shift = 1'b1;
      end
      SRA: begin
        f3    = 3'b101;
        shift = 1'b1;
        alt   = 1'b1;
      end
      OR:  f3 = 3'b110;
      AND: f3 = 3'b111;
      NOP: f3 = 3'b000;
      default: legal = 1'b0;
    endcase
  end
  assign f7   = alt ? 7'b0100000 : 7'b0000000;
  assign imm  = shift ? {f7, in_imm[4:0]} : in_imm;
  assign inst = (in_alu_op == NOP) ? 32'h0000_0013 :
                in_itype ? {imm, in_rs1, f3, in_rd, 7'b0010011} :
                           {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
  assign in_ready  = level < (AW+1)'(DEPTH);
  assign out_valid = level != '0;
  assign out_inst  = mem[rd_ptr];
  assign push      = in_valid && in_ready && legal;
  assign bad       = in_valid && in_ready && !legal;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      err_pulse <= 1'b0;
      err_count <= 8'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= inst;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level     <= level + (AW+1)'(push) - (AW+1)'(pop);
      err_pulse <= bad;
      if (bad && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: doc/alu_inst_encoder.md
ALU_INST_ENCODER -- requirements
Module: alu_inst_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, output FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid  input  1  encode request present.
REQ-005 The block SHALL have port in_ready  output  1  request accepted when in_valid & in_ready at a clk edge.
REQ-006 The block SHALL have port in_alu_op  input  4  ALU control code (ADD, SUB, SLL, LT, LTU, XOR, SRL, SRA, OR, AND, NOP per alu_controll.vh).
REQ-007 The block SHALL have port in_itype  input  1  1 = OP-IMM format (0010011), 0 = OP format (0110011).
REQ-008 The block SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-009 The block SHALL have port in_imm  input  12  I-type immediate.
REQ-010 The block SHALL have port out_valid  output  1  FIFO head holds an encoded instruction.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes head when out_valid & out_ready at a clk edge.
REQ-012 The block SHALL have port out_inst  output  32  encoded RV32I instruction at FIFO head.
REQ-013 The block SHALL have port level  output  $clog2(DEPTH)+1  number of FIFO entries.
REQ-014 The block SHALL have port err_pulse  output  1  one-cycle pulse for a rejected (illegal) request.
REQ-015 The block SHALL have port err_count  output  8  saturating count of illegal requests.

Function
REQ-016 The block SHALL be the inverse of the ALU control decoder: any legal out_inst, decoded, reproduces in_alu_op.
REQ-017 OP format SHALL encode {funct7, rs2, rs1, funct3, rd, 0110011}; funct7 = 0100000 for SUB/SRA, else 0000000.
REQ-018 funct3 SHALL be ADD/SUB 000, SLL 001, LT 010, LTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
REQ-019 OP-IMM format SHALL encode {imm[11:0], rs1, funct3, rd, 0010011}; in_rs2 ignored.
REQ-020 OP-IMM shifts SHALL force imm[11:5] = 0000000 (SLL/SRL) or 0100000 (SRA), imm[4:0] = in_imm[4:0].
REQ-021 NOP SHALL encode 0x00000013 regardless of in_itype and operand fields.
REQ-022 Illegal requests (SUB with in_itype=1, any undefined in_alu_op code) SHALL be consumed (handshake completes), not written to the FIFO, pulse err_pulse in the following cycle, and increment err_count saturating at 255.
REQ-023 in_ready SHALL equal (level < DEPTH), independent of in_valid and out_ready (no combinational path in->out).
REQ-024 A legal accepted request SHALL be encoded and written at the accepting edge; out_valid rises one cycle later at the earliest (latency 1).
REQ-025 out_inst SHALL be driven from a register/FIFO entry and held stable while out_valid & !out_ready.
REQ-026 FIFO SHALL be strict in-order; read/write pointers wrap modulo DEPTH.
REQ-027 Simultaneous push and pop SHALL leave level unchanged; when full, in_ready=0 so no push occurs that cycle even if popping.
REQ-028 out_valid SHALL equal (level != 0); pop when empty SHALL have no effect.

Reset
REQ-029 With rst_n=0 at a clk edge: level=0, pointers=0, out_valid=0, err_pulse=0, err_count=0, in_ready=1 from the next cycle.
REQ-030 Reset asserted mid-operation SHALL discard all FIFO contents and any same-cycle handshake; out_inst value is don't-care while out_valid=0.

Verification
REQ-031 ADD R rd=1 rs1=2 rs2=3 with out_ready=1 -> out_inst=0x003100B3, out_valid one cycle after acceptance.
REQ-032 SUB R rd=5 rs1=6 rs2=7, then ADD I rd=1 rs1=0 imm=0xFFF, then SRA I rd=2 rs1=2 imm=0x003 -> 0x407302B3, 0xFFF00093, 0x40315113 in order.
REQ-033 out_ready=0, push 5 legal requests (DEPTH=4) -> in_ready=0 after 4th, level=4, 5th held; raise out_ready -> 5th accepted, all 5 emitted in order.
REQ-034 Full FIFO with in_valid=1 and out_ready=1 same cycle -> pop only, level 4->3; next cycle push accepted.
REQ-035 SUB with in_itype=1, then 300 more illegal requests -> no FIFO write, err_pulse per request, err_count stops at 255.
REQ-036 Fill 3 entries, assert rst_n=0 one cycle -> level=0, out_valid=0, err_count=0; next request emitted normally.
